// File: rtl/decode_stage_if.sv
`default_nettype none
// ============================================================================
// Module  : decode_stage_if
// Brief   : Upstream instruction handshake and downstream decoded bundle
//           for the MIPS decode stage.
// Revision: 1.0  initial release
// ============================================================================
interface decode_stage_if #(
    parameter int PC_W      = 32,
    parameter int IMM_W     = 32,
    parameter int ALU_CTR_W = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          in_instr;
    logic [PC_W-1:0]      in_pc;

    logic                 out_valid;
    logic                 out_ready;
    logic [4:0]           rs;
    logic [4:0]           rt;
    logic [4:0]           rd;
    logic [4:0]           shamt;
    logic [IMM_W-1:0]     imm_ext;
    logic                 reg_dst;
    logic                 reg_write;
    logic                 mem_read;
    logic                 mem_write;
    logic                 jump;
    logic                 branch;
    logic                 alu_src;
    logic                 illegal;
    logic [ALU_CTR_W-1:0] alu_ctr;
    logic [PC_W-1:0]      branch_target;
    logic [PC_W-1:0]      jump_target;

    // Stage side
    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, rs, rt, rd, shamt, imm_ext,
               reg_dst, reg_write, mem_read, mem_write, jump, branch,
               alu_src, illegal, alu_ctr, branch_target, jump_target
    );

    // Fetch / execute side
    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, rs, rt, rd, shamt, imm_ext,
               reg_dst, reg_write, mem_read, mem_write, jump, branch,
               alu_src, illegal, alu_ctr, branch_target, jump_target
    );
endinterface
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module  : decode_stage
// Brief   : Registered MIPS decode stage with valid/ready handshake, flush,
//           load-use bubble insertion and illegal-opcode flag.
// Revision: 1.0  initial release
// ============================================================================
module decode_stage #(
    parameter int PC_W      = 32,
    parameter int IMM_W     = 32,
    parameter int ALU_CTR_W = 4,
    parameter int HAZARD_EN = 1
) (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       flush,
    decode_stage_if.slave   bus
);
    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_ANDI  = 6'b001100;
    localparam logic [5:0] c_OP_ORI   = 6'b001101;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;

    localparam logic [5:0] c_FN_ADD   = 6'b100000;
    localparam logic [5:0] c_FN_ADDU  = 6'b100001;
    localparam logic [5:0] c_FN_SUB   = 6'b100010;
    localparam logic [5:0] c_FN_SUBU  = 6'b100011;
    localparam logic [5:0] c_FN_AND   = 6'b100100;
    localparam logic [5:0] c_FN_OR    = 6'b100101;
    localparam logic [5:0] c_FN_NOR   = 6'b100111;
    localparam logic [5:0] c_FN_SLT   = 6'b101010;

    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [15:0] w_imm16;

    assign w_op    = bus.in_instr[31:26];
    assign w_funct = bus.in_instr[5:0];
    assign w_rs    = bus.in_instr[25:21];
    assign w_rt    = bus.in_instr[20:16];
    assign w_imm16 = bus.in_instr[15:0];

    logic [3:0] w_alu4;
    logic       w_reg_dst, w_reg_write, w_mem_read, w_mem_write;
    logic       w_jump, w_branch, w_alu_src, w_illegal, w_zext, w_uses_rt;

    always_comb begin
        w_alu4      = 4'b0000;
        w_reg_dst   = 1'b0;
        w_reg_write = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_jump      = 1'b0;
        w_branch    = 1'b0;
        w_alu_src   = 1'b0;
        w_illegal   = 1'b0;
        w_zext      = 1'b0;
        w_uses_rt   = 1'b0;
        case (w_op)
            c_OP_RTYPE: begin
                w_uses_rt   = 1'b1;
                w_reg_dst   = 1'b1;
                w_reg_write = 1'b1;
                case (w_funct)
                    c_FN_ADD, c_FN_ADDU: w_alu4 = 4'b0000;
                    c_FN_SUB, c_FN_SUBU: w_alu4 = 4'b0001;
                    c_FN_AND:            w_alu4 = 4'b1001;
                    c_FN_OR:             w_alu4 = 4'b1010;
                    c_FN_NOR:            w_alu4 = 4'b1100;
                    c_FN_SLT:            w_alu4 = 4'b0111;
                    default: begin
                        w_illegal   = 1'b1;
                        w_reg_dst   = 1'b0;
                        w_reg_write = 1'b0;
                    end
                endcase
            end
            c_OP_ADDI: begin
                w_reg_write = 1'b1;
                w_alu_src   = 1'b1;
            end
            c_OP_ANDI: begin
                w_alu4      = 4'b1001;
                w_zext      = 1'b1;
                w_reg_write = 1'b1;
                w_alu_src   = 1'b1;
            end
            c_OP_ORI: begin
                w_alu4      = 4'b1010;
                w_zext      = 1'b1;
                w_reg_write = 1'b1;
                w_alu_src   = 1'b1;
            end
            c_OP_LW: begin
                w_mem_read  = 1'b1;
                w_reg_write = 1'b1;
                w_alu_src   = 1'b1;
            end
            c_OP_SW: begin
                w_uses_rt   = 1'b1;
                w_mem_write = 1'b1;
                w_alu_src   = 1'b1;
            end
            c_OP_BEQ: begin
                w_uses_rt   = 1'b1;
                w_alu4      = 4'b0001;
                w_branch    = 1'b1;
            end
            c_OP_J:  w_jump    = 1'b1;
            default: w_illegal = 1'b1;
        endcase
    end

    logic [IMM_W-1:0] w_imm_sext;
    logic [IMM_W-1:0] w_imm_zext;
    logic [PC_W-1:0]  w_pc4;
    logic [PC_W-1:0]  w_boff;
    logic [PC_W-1:0]  w_branch_target;
    logic [PC_W-1:0]  w_jump_target;

    assign w_imm_sext      = IMM_W'($signed(w_imm16));
    assign w_imm_zext      = IMM_W'(w_imm16);
    assign w_pc4           = bus.in_pc + PC_W'(4);
    assign w_boff          = PC_W'($signed({w_imm16, 2'b00}));
    assign w_branch_target = w_pc4 + w_boff;

    // With a 28-bit PC there are no region bits left to carry over.
    generate
        if (PC_W > 28) begin : g_jt_region
            assign w_jump_target = {w_pc4[PC_W-1:28], bus.in_instr[25:0], 2'b00};
        end else begin : g_jt_flat
            assign w_jump_target = {bus.in_instr[25:0], 2'b00};
        end
    endgenerate

    logic                 r_out_valid;
    logic [4:0]           r_rs, r_rt, r_rd, r_shamt;
    logic [IMM_W-1:0]     r_imm_ext;
    logic                 r_reg_dst, r_reg_write, r_mem_read, r_mem_write;
    logic                 r_jump, r_branch, r_alu_src, r_illegal;
    logic [ALU_CTR_W-1:0] r_alu_ctr;
    logic [PC_W-1:0]      r_branch_target, r_jump_target;

    logic w_slot_free;
    logic w_hazard;
    logic w_accept;

    // A held load whose destination is read by the incoming instruction.
    assign w_hazard = (HAZARD_EN != 0) && r_out_valid && r_mem_read &&
                      (r_rt != 5'd0) && bus.in_valid &&
                      ((w_rs == r_rt) || (w_uses_rt && (w_rt == r_rt)));

    assign w_slot_free  = !r_out_valid || bus.out_ready;
    assign bus.in_ready = w_slot_free && !w_hazard && !flush;
    assign w_accept     = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid     <= 1'b0;
            r_rs            <= '0;
            r_rt            <= '0;
            r_rd            <= '0;
            r_shamt         <= '0;
            r_imm_ext       <= '0;
            r_reg_dst       <= 1'b0;
            r_reg_write     <= 1'b0;
            r_mem_read      <= 1'b0;
            r_mem_write     <= 1'b0;
            r_jump          <= 1'b0;
            r_branch        <= 1'b0;
            r_alu_src       <= 1'b0;
            r_illegal       <= 1'b0;
            r_alu_ctr       <= '0;
            r_branch_target <= '0;
            r_jump_target   <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid     <= 1'b1;
            r_rs            <= w_rs;
            r_rt            <= w_rt;
            r_rd            <= bus.in_instr[15:11];
            r_shamt         <= bus.in_instr[10:6];
            r_imm_ext       <= w_zext ? w_imm_zext : w_imm_sext;
            r_reg_dst       <= w_reg_dst;
            r_reg_write     <= w_reg_write;
            r_mem_read      <= w_mem_read;
            r_mem_write     <= w_mem_write;
            r_jump          <= w_jump;
            r_branch        <= w_branch;
            r_alu_src       <= w_alu_src;
            r_illegal       <= w_illegal;
            r_alu_ctr       <= ALU_CTR_W'(w_alu4);
            r_branch_target <= w_branch_target;
            r_jump_target   <= w_jump_target;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.out_valid     = r_out_valid;
    assign bus.rs            = r_rs;
    assign bus.rt            = r_rt;
    assign bus.rd            = r_rd;
    assign bus.shamt         = r_shamt;
    assign bus.imm_ext       = r_imm_ext;
    assign bus.reg_dst       = r_reg_dst;
    assign bus.reg_write     = r_reg_write;
    assign bus.mem_read      = r_mem_read;
    assign bus.mem_write     = r_mem_write;
    assign bus.jump          = r_jump;
    assign bus.branch        = r_branch;
    assign bus.alu_src       = r_alu_src;
    assign bus.illegal       = r_illegal;
    assign bus.alu_ctr       = r_alu_ctr;
    assign bus.branch_target = r_branch_target;
    assign bus.jump_target   = r_jump_target;
endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_decode_stage
// Brief   : Directed bench for decode_stage; u_dut has hazard detection on,
//           u_nohz has it off and sees identical stimulus.
// Revision: 1.0  initial release
// ============================================================================
module tb_decode_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic        out_ready = 1'b1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    decode_stage_if #(.PC_W(32), .IMM_W(32), .ALU_CTR_W(4)) bus0 ();
    decode_stage_if #(.PC_W(32), .IMM_W(32), .ALU_CTR_W(4)) bus1 ();

    assign bus0.in_valid  = in_valid;
    assign bus0.in_instr  = in_instr;
    assign bus0.in_pc     = in_pc;
    assign bus0.out_ready = out_ready;
    assign bus1.in_valid  = in_valid;
    assign bus1.in_instr  = in_instr;
    assign bus1.in_pc     = in_pc;
    assign bus1.out_ready = out_ready;

    decode_stage #(.PC_W(32), .IMM_W(32), .ALU_CTR_W(4), .HAZARD_EN(1)) u_dut (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus0.slave)
    );
    decode_stage #(.PC_W(32), .IMM_W(32), .ALU_CTR_W(4), .HAZARD_EN(0)) u_nohz (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus1.slave)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_out_valid", bus0.out_valid, 0);
        chk("rst_rs", bus0.rs, 0);
        rst = 1'b0;

        // Accept one, then reset asynchronously with another accept pending
        drive(32'h00A41020, 32'h0000_0100);
        tick();
        chk("pre_rst_valid", bus0.out_valid, 1);
        chk("pre_rst_rs", bus0.rs, 5);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", bus0.out_valid, 0);
        chk("async_rst_rs", bus0.rs, 0);
        chk("async_rst_rt", bus0.rt, 0);
        chk("async_rst_rd", bus0.rd, 0);
        chk("async_rst_regwr", bus0.reg_write, 0);
        chk("async_rst_bt", bus0.branch_target, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("add_valid", bus0.out_valid, 1);
        chk("add_rs", bus0.rs, 5);
        chk("add_rt", bus0.rt, 4);
        chk("add_rd", bus0.rd, 2);
        chk("add_alu", bus0.alu_ctr, 4'b0000);
        chk("add_regdst", bus0.reg_dst, 1);
        chk("add_regwr", bus0.reg_write, 1);
        chk("add_alusrc", bus0.alu_src, 0);

        // Decode sweep, streaming back-to-back
        drive(32'h3085FFFF, 32'h0000_0104);
        tick();
        chk("andi_imm", bus0.imm_ext, 32'h0000FFFF);
        chk("andi_alu", bus0.alu_ctr, 4'b1001);
        chk("andi_alusrc", bus0.alu_src, 1);
        chk("andi_regdst", bus0.reg_dst, 0);
        drive(32'h2085FFFF, 32'h0000_0108);
        tick();
        chk("addi_imm", bus0.imm_ext, 32'hFFFFFFFF);
        chk("addi_alu", bus0.alu_ctr, 4'b0000);
        chk("addi_regwr", bus0.reg_write, 1);
        drive(32'hAC850008, 32'h0000_010C);
        tick();
        chk("sw_memwr", bus0.mem_write, 1);
        chk("sw_regwr", bus0.reg_write, 0);
        chk("sw_imm", bus0.imm_ext, 32'h00000008);
        drive(32'hFC000000, 32'h0000_0110);
        tick();
        chk("ill_valid", bus0.out_valid, 1);
        chk("ill_flag", bus0.illegal, 1);
        chk("ill_ctrl", {bus0.reg_dst, bus0.reg_write, bus0.mem_read, bus0.mem_write,
                         bus0.jump, bus0.branch, bus0.alu_src}, 0);
        chk("ill_alu", bus0.alu_ctr, 0);

        // Branch / jump targets
        drive(32'h1000FFFF, 32'h0040_0000);
        tick();
        chk("beq_target", bus0.branch_target, 32'h0040_0000);
        chk("beq_branch", bus0.branch, 1);
        chk("beq_alu", bus0.alu_ctr, 4'b0001);
        drive(32'h08000010, 32'h1000_0000);
        tick();
        chk("j_target", bus0.jump_target, 32'h1000_0040);
        chk("j_jump", bus0.jump, 1);

        // Load-use: lw $8,0($9) then add $10,$8,$3
        drive(32'h8D280000, 32'h0000_0200);
        tick();
        chk("lw_memrd", bus0.mem_read, 1);
        chk("lw_rt", bus0.rt, 8);
        drive(32'h01035020, 32'h0000_0204);
        #1;
        chk("hz_in_ready", bus0.in_ready, 0);
        chk("nohz_in_ready", bus1.in_ready, 1);
        tick();
        chk("hz_bubble", bus0.out_valid, 0);
        chk("nohz_valid", bus1.out_valid, 1);
        chk("nohz_rd", bus1.rd, 10);
        chk("hz_ready_after", bus0.in_ready, 1);
        tick();
        chk("hz_dep_valid", bus0.out_valid, 1);
        chk("hz_dep_rd", bus0.rd, 10);

        // Load to $0 never stalls
        drive(32'h8D200000, 32'h0000_0300);
        tick();
        chk("lw0_memrd", bus0.mem_read, 1);
        drive(32'h00035020, 32'h0000_0304);
        #1;
        chk("lw0_in_ready", bus0.in_ready, 1);
        tick();
        chk("lw0_dep_valid", bus0.out_valid, 1);
        chk("lw0_dep_rd", bus0.rd, 10);

        // Backpressure
        drive(32'h34851234, 32'h0000_0400);
        tick();
        chk("ori_alu", bus0.alu_ctr, 4'b1010);
        out_ready = 1'b0;
        drive(32'h00221822, 32'h0000_0404);
        #1;
        chk("bp_in_ready", bus0.in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_valid", bus0.out_valid, 1);
            chk("bp_imm", bus0.imm_ext, 32'h00001234);
            chk("bp_rt", bus0.rt, 5);
            chk("bp_in_ready_hold", bus0.in_ready, 0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", bus0.in_ready, 1);
        tick();
        chk("sub_valid", bus0.out_valid, 1);
        chk("sub_alu", bus0.alu_ctr, 4'b0001);
        chk("sub_rd", bus0.rd, 3);

        // Flush
        drive(32'h00A62027, 32'h0000_0500);
        flush = 1'b1;
        #1;
        chk("fl_in_ready", bus0.in_ready, 0);
        tick();
        chk("fl_valid", bus0.out_valid, 0);
        flush = 1'b0;
        #1;
        chk("fl_ready_after", bus0.in_ready, 1);
        tick();
        chk("nor_valid", bus0.out_valid, 1);
        chk("nor_alu", bus0.alu_ctr, 4'b1100);
        chk("nor_rd", bus0.rd, 4);

        // Drain
        in_valid = 1'b0;
        tick();
        chk("drain_valid", bus0.out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
